mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  - Shares the core's single memory port between fetch (IF) and load/store (LS).
//  - Accepts one request per side and issues at most one outstanding transaction to memory.
//  - Returns each response only to the requester that issued it.
//  - Sits between the fetch/execute units and the unified memory. LS has priority by default.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width
//  MAX_WAIT  4   IF arbitration losses before IF is forced to win (only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  if_req_i      in   1   fetch request; held with if_addr_i until if_gnt_o
//  if_addr_i     in   AW  fetch address
//  if_gnt_o      out  1   fetch request accepted (1-cycle pulse)
//  if_rvalid_o   out  1   fetch response valid (1-cycle pulse)
//  if_rdata_o    out  DW  fetch read data
//  ls_req_i      in   1   load/store request; held stable until ls_gnt_o
//  ls_we_i       in   1   1 = store, 0 = load
//  ls_addr_i     in   AW  load/store address
//  ls_wdata_i    in   DW  store data
//  ls_wsize_i    in   2   store size: 0 = byte, 1 = half, 2 = word
//  ls_gnt_o      out  1   load/store request accepted (1-cycle pulse)
//  ls_rvalid_o   out  1   load data valid, or store complete (1-cycle pulse)
//  ls_rdata_o    out  DW  load read data
//  mem_req_o     out  1   memory request
//  mem_we_o      out  1   memory write enable
//  mem_addr_o    out  AW  memory address
//  mem_wdata_o   out  DW  memory write data
//  mem_wsize_o   out  2   memory write size
//  mem_gnt_i     in   1   memory accepted the request this cycle
//  mem_rvalid_i  in   1   memory response valid
//  mem_rdata_i   in   DW  memory response data
// BEHAVIOUR
//  - FSM states: IDLE, WAIT_IF, WAIT_LS. Reset state is IDLE.
//  - Reset: all outputs 0; starvation counter 0; any outstanding response is discarded.
//  - Reset is asynchronous and may arrive mid-transaction; the FSM goes straight to IDLE.
//  - IDLE, arbitration (combinational):
//      - Winner is LS if ls_req_i, else IF if if_req_i.
//      - mem_req_o = winner present. mem_* fields are muxed from the winner.
//      - When IF wins: mem_we_o = 0, mem_wdata_o = 0, mem_wsize_o = 2.
//  - IDLE with mem_gnt_i & mem_req_o:
//      - The winner's gnt_o pulses in the same cycle.
//      - Next state is WAIT_IF or WAIT_LS, matching the winner.
//  - IDLE with mem_req_o & !mem_gnt_i: stay in IDLE and re-arbitrate next cycle.
//      - A newly raised ls_req_i may overtake a waiting IF request.
//  - WAIT_x:
//      - mem_req_o = 0; no grant is possible.
//      - On mem_rvalid_i: owner's rvalid_o = 1 and rdata_o = mem_rdata_i, same cycle
//        (combinational pass-through). Next state is IDLE.
//  - Non-owner rvalid_o is always 0. rdata_o is 0 whenever rvalid_o = 0.
//  - Stores also complete with an ls_rvalid_o pulse; rdata is don't-care.
//  - Throughput: minimum 2 cycles per transaction (grant cycle, then response cycle).
//      - No new grant in the cycle mem_rvalid_i is accepted.
//      - Back-to-back: gnt at cycle t, rvalid at t+1, next gnt at t+2 at the earliest.
//  - mem_rvalid_i while in IDLE is a stray response: ignored, no rvalid_o.
//  - mem_gnt_i with mem_req_o = 0 is ignored.
//  - A requester dropping req before its gnt is legal; arbitration simply re-evaluates.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//    - A saturating 3-bit counter increments each cycle IF requests in IDLE and LS is granted.
//    - Counter clears when IF is granted or if_req_i is low.
//    - When counter == MAX_WAIT, IF wins IDLE arbitration even if ls_req_i = 1.
//  ARB_STARVE_GUARD_EN undefined:
//    - Strict LS priority. The counter is not built, and IF can be starved indefinitely.
// TESTING
//  - Single fetch: if_req_i = 1, if_addr_i = 0x100, mem_gnt_i = 1
//      -> mem_addr_o = 0x100 and if_gnt_o pulse that cycle.
//      -> Next cycle mem_rvalid_i = 1, rdata = 0x00000013 -> if_rvalid_o = 1, if_rdata_o = 0x13.
//      -> ls_rvalid_o = 0 throughout.
//  - Collision: if_req_i and ls_req_i (load, 0x2000) both raised the same cycle
//      -> ls_gnt_o first and mem_addr_o = 0x2000.
//      -> After its response, if_gnt_o in the next IDLE cycle.
//  - Store: ls_we_i = 1, addr 0x40, wdata 0xDEADBEEF, wsize 0
//      -> mem_we_o = 1, mem_wsize_o = 0; ls_rvalid_o pulses when mem_rvalid_i arrives.
//  - Memory stall: mem_gnt_i = 0 for 3 cycles
//      -> mem_req_o stays 1, no gnt_o; gnt_o is issued on the 4th cycle when mem_gnt_i = 1.
//  - Reset in WAIT_LS, then mem_rvalid_i after reset release
//      -> outputs 0, state IDLE, ls_rvalid_o stays 0 (stray response ignored).
//  - Starvation guard (macro on, MAX_WAIT = 4): ls_req_i and if_req_i held high
//      -> if_gnt_o on the 5th arbitration.
//      -> With the macro off, if_gnt_o never asserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS), one transaction in flight.
// Optional IF starvation guard is built when ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [DW-1:0] if_rdata_o,
   input  logic          ls_req_i,
   input  logic          ls_we_i,
   input  logic [AW-1:0] ls_addr_i,
   input  logic [DW-1:0] ls_wdata_i,
   input  logic [1:0]    ls_wsize_i,
   output logic          ls_gnt_o,
   output logic          ls_rvalid_o,
   output logic [DW-1:0] ls_rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic [1:0]    mem_wsize_o,
   input  logic          mem_gnt_i,
   input  logic          mem_rvalid_i,
   input  logic [DW-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LS} state_t;

   state_t state;
   logic   idle;
   logic   ls_win;
   logic   if_win;
   logic   force_if;

   if (MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_bad_max_wait
      $error("MAX_WAIT must fit the 3-bit starvation counter");
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [2:0] MAX_W = 3'(MAX_WAIT);
   logic [2:0] starve_cnt;

   assign force_if = (starve_cnt == MAX_W);

   // Counts LS wins while IF is waiting; saturates so it never wraps past the threshold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else if (!if_req_i || if_gnt_o)
         starve_cnt <= '0;
      else if (ls_gnt_o && starve_cnt != 3'd7)
         starve_cnt <= starve_cnt + 3'd1;
   end
`else
   assign force_if = 1'b0;
`endif

   // Outputs are forced low while reset is held, even though the arbitration is combinational.
   assign idle   = (state == IDLE) && !rst;
   assign ls_win = idle && ls_req_i && !(force_if && if_req_i);
   assign if_win = idle && if_req_i && !ls_win;

   assign ls_gnt_o = ls_win && mem_gnt_i;
   assign if_gnt_o = if_win && mem_gnt_i;

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wsize_o = 2'd0;
      if (ls_win) begin
         mem_req_o   = 1'b1;
         mem_we_o    = ls_we_i;
         mem_addr_o  = ls_addr_i;
         mem_wdata_o = ls_wdata_i;
         mem_wsize_o = ls_wsize_i;
      end else if (if_win) begin
         mem_req_o   = 1'b1;
         mem_addr_o  = if_addr_i;
         mem_wsize_o = 2'd2;
      end
   end

   // Responses pass straight through to the owner; rvalid in IDLE is a stray and dropped.
   assign if_rvalid_o = !rst && (state == WAIT_IF) && mem_rvalid_i;
   assign ls_rvalid_o = !rst && (state == WAIT_LS) && mem_rvalid_i;
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
   assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else begin
         case (state)
            IDLE: begin
               if (ls_gnt_o)
                  state <= WAIT_LS;
               else if (if_gnt_o)
                  state <= WAIT_IF;
            end
            WAIT_IF, WAIT_LS: begin
               if (mem_rvalid_i)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers one cycle after each
// accepted request; expected read data is queued per requester when the request is driven.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MAX_WAIT = 4;

   logic          clk;
   logic          rst;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o;
   logic          if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          ls_req_i;
   logic          ls_we_i;
   logic [AW-1:0] ls_addr_i;
   logic [DW-1:0] ls_wdata_i;
   logic [1:0]    ls_wsize_i;
   logic          ls_gnt_o;
   logic          ls_rvalid_o;
   logic [DW-1:0] ls_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [1:0]    mem_wsize_o;
   logic          mem_gnt_i;
   logic          mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;

   int            n_tests = 0;
   int            n_fail  = 0;
   bit            rsp_en  = 1'b1;
   logic [31:0]   if_q[$];
   logic [31:0]   ls_q[$];

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
      .ls_wdata_i(ls_wdata_i), .ls_wsize_i(ls_wsize_i), .ls_gnt_o(ls_gnt_o),
      .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wsize_o(mem_wsize_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Memory model: a request accepted in one cycle is answered in the next.
   initial begin
      logic        acc;
      logic [31:0] a;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(negedge clk);
         acc = mem_req_o && mem_gnt_i;
         a   = mem_addr_o;
         @(posedge clk);
         #1;
         if (rsp_en) begin
            mem_rvalid_i = acc;
            mem_rdata_i  = acc ? rd_of(a) : '0;
         end
      end
   end

   // Response monitor: pops the scoreboard whenever a requester sees rvalid.
   initial begin
      forever begin
         @(negedge clk);
         if (if_rvalid_o) begin
            if (if_q.size() == 0) chk("if_unexpected_rvalid", 32'(if_rvalid_o), 32'd0);
            else                  chk("if_rdata", if_rdata_o, if_q.pop_front());
         end else
            chk("if_rdata_idle", if_rdata_o, 32'd0);
         if (ls_rvalid_o) begin
            if (ls_q.size() == 0) chk("ls_unexpected_rvalid", 32'(ls_rvalid_o), 32'd0);
            else                  chk("ls_rdata", ls_rdata_o, ls_q.pop_front());
         end else
            chk("ls_rdata_idle", ls_rdata_o, 32'd0);
      end
   end

   initial begin
      bit exp_if;
      rst = 1'b1;
      if_req_i = 1'b1; if_addr_i = 32'h100;
      ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_wsize_i = 2'd2;
      mem_gnt_i = 1'b1;

      // reset holds every output low even with a request and a grant present
      smp();
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_if_gnt", 32'(if_gnt_o), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      step(); rst = 1'b0; if_req_i = 1'b0;
      step();

      // single fetch
      if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
      if_q.push_back(rd_of(32'h100));
      smp();
      chk("f_mem_req", 32'(mem_req_o), 32'd1);
      chk("f_mem_addr", mem_addr_o, 32'h100);
      chk("f_if_gnt", 32'(if_gnt_o), 32'd1);
      chk("f_ls_gnt", 32'(ls_gnt_o), 32'd0);
      chk("f_we", 32'(mem_we_o), 32'd0);
      chk("f_wsize", 32'(mem_wsize_o), 32'd2);
      chk("f_wdata", mem_wdata_o, 32'd0);
      step(); if_req_i = 1'b0;
      smp();
      chk("f_wait_req", 32'(mem_req_o), 32'd0);
      chk("f_if_rvalid", 32'(if_rvalid_o), 32'd1);
      chk("f_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
      step(); step();

      // collision: LS wins, IF granted two cycles later
      if_req_i = 1'b1; if_addr_i = 32'h1234;
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h2000;
      ls_q.push_back(rd_of(32'h2000));
      if_q.push_back(rd_of(32'h1234));
      smp();
      chk("c_ls_gnt", 32'(ls_gnt_o), 32'd1);
      chk("c_if_gnt0", 32'(if_gnt_o), 32'd0);
      chk("c_addr", mem_addr_o, 32'h2000);
      step(); ls_req_i = 1'b0;
      smp();
      chk("c_wait_req", 32'(mem_req_o), 32'd0);
      chk("c_if_gnt1", 32'(if_gnt_o), 32'd0);
      step();
      smp();
      chk("c_if_gnt2", 32'(if_gnt_o), 32'd1);
      chk("c_if_addr", mem_addr_o, 32'h1234);
      step(); if_req_i = 1'b0;
      step();

      // byte store
      ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h40;
      ls_wdata_i = 32'hDEAD_BEEF; ls_wsize_i = 2'd0;
      ls_q.push_back(rd_of(32'h40));
      smp();
      chk("s_gnt", 32'(ls_gnt_o), 32'd1);
      chk("s_we", 32'(mem_we_o), 32'd1);
      chk("s_wsize", 32'(mem_wsize_o), 32'd0);
      chk("s_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      step(); ls_req_i = 1'b0; ls_we_i = 1'b0; ls_wdata_i = '0; ls_wsize_i = 2'd2;
      smp();
      chk("s_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
      step(); step();

      // memory stall for three cycles, grant on the fourth
      if_req_i = 1'b1; if_addr_i = 32'h300; mem_gnt_i = 1'b0;
      if_q.push_back(rd_of(32'h300));
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("st_req", 32'(mem_req_o), 32'd1);
         chk("st_no_gnt", 32'(if_gnt_o), 32'd0);
         step();
      end
      mem_gnt_i = 1'b1;
      smp();
      chk("st_gnt", 32'(if_gnt_o), 32'd1);
      chk("st_addr", mem_addr_o, 32'h300);
      step(); if_req_i = 1'b0;
      step(); step();

      // reset during WAIT_LS, then a stray response after release
      rsp_en = 1'b0;
      step();
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h500; mem_rvalid_i = 1'b0;
      smp();
      chk("r_ls_gnt", 32'(ls_gnt_o), 32'd1);
      step(); ls_req_i = 1'b0; rst = 1'b1;
      smp();
      chk("r_mem_req", 32'(mem_req_o), 32'd0);
      chk("r_ls_rvalid", 32'(ls_rvalid_o), 32'd0);
      step(); rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
      smp();
      chk("r_stray_rvalid", 32'(ls_rvalid_o), 32'd0);
      chk("r_stray_if", 32'(if_rvalid_o), 32'd0);
      step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0; rsp_en = 1'b1;
      if_req_i = 1'b1; if_addr_i = 32'h700;
      if_q.push_back(rd_of(32'h700));
      smp();
      chk("r_idle_gnt", 32'(if_gnt_o), 32'd1);
      step(); if_req_i = 1'b0;
      step(); step();

      // both held high: LS always wins unless the starvation guard is built
      ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h600;
      if_req_i = 1'b1; if_addr_i = 32'h800;
      for (int k = 1; k <= 6; k++) begin
`ifdef ARB_STARVE_GUARD_EN
         exp_if = (k == MAX_WAIT + 1);
`else
         exp_if = 1'b0;
`endif
         if (exp_if) if_q.push_back(rd_of(32'h800));
         else        ls_q.push_back(rd_of(32'h600));
         smp();
         chk($sformatf("sv_if_gnt_%0d", k), 32'(if_gnt_o), 32'(exp_if));
         chk($sformatf("sv_ls_gnt_%0d", k), 32'(ls_gnt_o), 32'(!exp_if));
         step();
         if (exp_if) if_req_i = 1'b0;
         smp();
         step();
      end
      ls_req_i = 1'b0; if_req_i = 1'b0;
      repeat (4) step();

      chk("if_q_drained", 32'(if_q.size()), 32'd0);
      chk("ls_q_drained", 32'(ls_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
